// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, port ids and default widths for
// the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 16;
    localparam int RAM_DATA_W = 32;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way request pick with last-grant memory.
// Define RAM_ARB_FIXED_PRIO_EN to make port 1 win every tie.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_upd,
    output logic o_grant
);

    logic r_last;

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        o_grant = i_req1 ? PORT_DATA : PORT_IFETCH;
    end

    // Last grant is meaningless here; it stays pinned to port 1.
    always_ff @(posedge clk) begin
        if (rst || i_upd) begin
            r_last <= PORT_DATA;
        end
    end
`else
    always_comb begin
        o_grant = PORT_IFETCH;
        if (i_req0 && i_req1) begin
            o_grant = ~r_last;
        end else if (i_req1) begin
            o_grant = PORT_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= PORT_DATA;
        end else if (i_upd) begin
            r_last <= o_grant;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: req/ack arbiter and sequencer in front of the 64K x 32
// single-port RAM. Optional macro: RAM_ARB_FIXED_PRIO_EN (port 1 wins ties).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              write_enable,
    output logic              read_enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_input,
    input  logic [DATA_W-1:0] data_output
);

    state_t            r_state;
    state_t            w_next;
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_grant;
    logic              w_take;

    assign w_take = (r_state == IDLE) && (req0 || req1);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req0  (req0),
        .i_req1  (req1),
        .i_upd   (w_take),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_take ? ISSUE : IDLE;
            ISSUE:   w_next = r_we ? RESP : WAIT;
            WAIT:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request fields are only looked at when a grant is taken in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port   <= PORT_IFETCH;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_take) begin
            r_port  <= w_grant;
            r_we    <= w_grant ? we1 : we0;
            r_addr  <= w_grant ? addr1 : addr0;
            r_wdata <= w_grant ? wdata1 : wdata0;
        end else if (r_state == WAIT) begin
            if (r_port == PORT_DATA) begin
                r_rdata1 <= data_output;
            end else begin
                r_rdata0 <= data_output;
            end
        end
    end

    always_comb begin
        read_enable  = 1'b0;
        write_enable = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;
        unique case (r_state)
            ISSUE: begin
                read_enable  = !r_we;
                write_enable = r_we;
            end
            RESP: begin
                ack0 = (r_port == PORT_IFETCH);
                ack1 = (r_port == PORT_DATA);
            end
            default: begin
            end
        endcase
    end

    assign address    = r_addr;
    assign data_input = r_wdata;
    assign rdata0     = r_rdata0;
    assign rdata1     = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed tests for ram_arbiter against a behavioural
// single-port RAM with one cycle of read latency.
module tb_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam logic [DW-1:0] D10 = 32'hA5A5_0010;
    localparam logic [DW-1:0] D20 = 32'h5A5A_0020;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          write_enable, read_enable;
    logic [AW-1:0] address;
    logic [DW-1:0] data_input;
    logic [DW-1:0] data_output;

    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] ram_q = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (write_enable) mem[address] <= data_input;
        if (read_enable) ram_q <= mem[address];
    end
    assign data_output = ram_q;

    ram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .ack0         (ack0),
        .rdata0       (rdata0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .ack1         (ack1),
        .rdata1       (rdata1),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .address      (address),
        .data_input   (data_input),
        .data_output  (data_output)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic p, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        int n;
        if (p) begin
            req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!(p ? ack1 : ack0) && n < 10);
        n_checks++;
        if (n >= 10) begin
            n_fail++;
            $display("FAIL preload_write: no ack on port %0d", p);
        end
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_checks += 4;
        if ({ack0, ack1, read_enable, write_enable} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {ack0, ack1, read_enable, write_enable});
        end
        if (address !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0h want 0", address);
        end
        if (data_input !== '0) begin
            n_fail++;
            $display("FAIL reset_din: got %0h want 0", data_input);
        end
        if (rdata0 !== '0 || rdata1 !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %0h/%0h want 0/0", rdata0, rdata1);
        end
    endtask

    task automatic test_write();
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd66; wdata1 = 32'd20;
        tick();
        n_checks += 3;
        if (write_enable !== 1'b1 || read_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_enables: we=%b re=%b want 1/0",
                     write_enable, read_enable);
        end
        if (address !== 16'd66) begin
            n_fail++;
            $display("FAIL wr_addr: got %0d want 66", address);
        end
        if (data_input !== 32'd20) begin
            n_fail++;
            $display("FAIL wr_data: got %0d want 20", data_input);
        end
        tick();
        n_checks += 2;
        if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack: ack1=%b ack0=%b want 1/0", ack1, ack0);
        end
        if (write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_we_resp: got %b want 0", write_enable);
        end
        req1 = 1'b0; we1 = 1'b0;
        tick();
        n_checks++;
        if (ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack_pulse: got %b want 0", ack1);
        end
    endtask

    task automatic test_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd66;
        tick();
        n_checks += 2;
        if (read_enable !== 1'b1 || write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_enables: re=%b we=%b want 1/0",
                     read_enable, write_enable);
        end
        if (address !== 16'd66) begin
            n_fail++;
            $display("FAIL rd_addr: got %0d want 66", address);
        end
        addr0 = 16'd99;
        tick();
        n_checks++;
        if (read_enable !== 1'b0 || ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_wait: re=%b ack0=%b want 0/0", read_enable, ack0);
        end
        tick();
        n_checks += 3;
        if (ack0 !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_ack: got %b want 1", ack0);
        end
        if (rdata0 !== 32'd20) begin
            n_fail++;
            $display("FAIL rd_data: got %0d want 20", rdata0);
        end
        if (rdata1 !== '0) begin
            n_fail++;
            $display("FAIL rd_other_rdata: got %0h want 0", rdata1);
        end
        req0 = 1'b0;
        tick();
        n_checks++;
        if (ack0 !== 1'b0 || rdata0 !== 32'd20) begin
            n_fail++;
            $display("FAIL rd_hold: ack0=%b rdata0=%0d want 0/20", ack0, rdata0);
        end
    endtask

    task automatic test_round_robin();
        int  n;
        logic p;
        logic exp_p;
        do_write(1'b1, 16'd10, D10);
        do_write(1'b0, 16'd20, D20);
        // Reset restores last_grant=1 so the first tie goes to port 0.
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd20;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!(ack0 || ack1) && n < 10);
            n_checks++;
            if (n >= 10) begin
                n_fail++;
                $display("FAIL rr_timeout: txn %0d no ack", t);
                break;
            end
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_p = 1'b1;
`else
            exp_p = (t % 2 == 1);
`endif
            p = ack1;
            n_checks += 3;
            if (p !== exp_p || (ack0 && ack1)) begin
                n_fail++;
                $display("FAIL rr_order: txn %0d acks %b%b want port %0d",
                         t, ack1, ack0, exp_p);
            end
            if ((p ? rdata1 : rdata0) !== (p ? D20 : D10)) begin
                n_fail++;
                $display("FAIL rr_data: txn %0d got %0h want %0h", t,
                         p ? rdata1 : rdata0, p ? D20 : D10);
            end
            if (n != 3) begin
                n_fail++;
                $display("FAIL rr_latency: txn %0d got %0d want 3", t, n);
            end
            if (p) req1 = 1'b0; else req0 = 1'b0;
            tick();
            if (p) req1 = 1'b1; else req0 = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd10; wdata0 = '0;
        tick();
        n_checks++;
        if (read_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_issue: re=%b want 1", read_enable);
        end
        tick();
        rst = 1'b1;
        tick();
        n_checks += 3;
        if ({ack0, ack1, read_enable, write_enable} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rm_ctrl: got %b want 0000",
                     {ack0, ack1, read_enable, write_enable});
        end
        if (address !== '0 || data_input !== '0) begin
            n_fail++;
            $display("FAIL rm_bus: addr=%0h din=%0h want 0/0",
                     address, data_input);
        end
        if (rdata0 !== '0 || rdata1 !== '0) begin
            n_fail++;
            $display("FAIL rm_rdata: got %0h/%0h want 0/0", rdata0, rdata1);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (read_enable !== 1'b1 || address !== 16'd10) begin
            n_fail++;
            $display("FAIL rm_fresh_issue: re=%b addr=%0d want 1/10",
                     read_enable, address);
        end
        tick();
        tick();
        n_checks++;
        if (ack0 !== 1'b1 || rdata0 !== D10) begin
            n_fail++;
            $display("FAIL rm_fresh_ack: ack0=%b rdata0=%0h want 1/%0h",
                     ack0, rdata0, D10);
        end
        req0 = 1'b0;
        tick();
    endtask

    task automatic test_req_drop();
        int extra;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd20;
        tick();
        n_checks++;
        if (read_enable !== 1'b1 || address !== 16'd20) begin
            n_fail++;
            $display("FAIL drop_issue: re=%b addr=%0d want 1/20",
                     read_enable, address);
        end
        req1 = 1'b0;
        tick();
        n_checks++;
        if (ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_early_ack: got %b want 0", ack1);
        end
        tick();
        n_checks++;
        if (ack1 !== 1'b1 || rdata1 !== D20) begin
            n_fail++;
            $display("FAIL drop_ack: ack1=%b rdata1=%0h want 1/%0h",
                     ack1, rdata1, D20);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (read_enable || write_enable || ack0 || ack1) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL drop_second_access: %0d busy cycles want 0", extra);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_mid();
        test_req_drop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
